mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Iterative RV64M multiply/divide unit directly downstream of the operand-select stage.
- Consumes `opnum1` and `opnum2` (rs1 and rs2 values) together with a 4-bit M-extension opcode.
- Produces a 64-bit result through a valid/ready handshake.
- The pipeline controller stalls writeback while the unit is busy; flush aborts an in-flight operation.

Parameters:
- XLEN, 64: datapath width; matches the global `RegBus` width.
- CNT_W, 7: iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  Core clock. Single clock domain.
- rst_n  input  1  Asynchronous, active-low reset.
- in_valid  input  1  Operands and op are valid this cycle.
- in_ready  output  1  Unit is idle and can accept an operation.
- op  input  4  Opcode: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU, 8 MULW, 9 DIVW, 10 DIVUW, 11 REMW, 12 REMUW. Codes 13–15 are reserved.
- opnum1  input  XLEN  Operand 1 (rs1), from the operand-select stage.
- opnum2  input  XLEN  Operand 2 (rs2), from the operand-select stage.
- flush  input  1  Abort the current operation. Takes priority over everything else.
- out_valid  output  1  Result is valid.
- out_ready  input  1  Downstream accepts the result.
- result  output  XLEN  Final result.
- busy  output  1  High in every state except IDLE. Used for the stall request.

Behaviour:
- Reset (async, rst_n low) clears everything immediately:
  - State goes to IDLE.
  - in_ready=1, out_valid=0, result=0, busy=0, counter=0.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch op and operands.
  - For W ops, replace the operands with their low 32 bits, sign-extended (signed ops) or zero-extended (unsigned ops).
  - Take absolute values for signed operands. Record the result sign.
  - Load the counter with N (N=32 for W ops, XLEN otherwise).
  - Next state is CALC, unless a special case applies; special cases go straight to DONE.
- Special cases (division only), each with a 1-cycle result, so out_valid rises the cycle after accept:
  - Divide by zero (divisor==0): quotient = all ones; remainder = dividend.
    - For W ops, the result is the 32-bit value sign-extended.
  - Signed overflow (dividend = most-negative, divisor = -1, at the op's width): quotient = dividend; remainder = 0.
- CALC:
  - Multiply: radix-2 shift-add over a 2N-bit accumulator.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
  - Counter decrements every cycle. When the counter reaches 1, next state is FIX.
- FIX (1 cycle):
  - Apply the sign: negate the product if the operand signs differ (MULH/MULHSU); quotient sign = XOR of the operand signs; remainder takes the dividend's sign.
  - Select the output:
    - low XLEN bits: MUL
    - high XLEN bits: MULH, MULHSU, MULHU
    - low 32 bits, sign-extended: all W ops
  - Register the result. Next state is DONE.
- DONE:
  - out_valid=1 and result is held stable until out_ready.
  - On out_valid && out_ready, go to IDLE. in_ready returns the next cycle; back-to-back accept in the DONE cycle is not allowed.
- Latency (accept edge = cycle 0):
  - Normal ops: out_valid in cycle N+2 (66 for 64-bit ops, 34 for W ops).
  - Special cases: cycle 1.
- Flush:
  - From any state: next state is IDLE and out_valid drops the next cycle.
  - No result is produced. An in_valid in the same cycle is ignored.
- Reserved op codes are accepted and complete on the 1-cycle path with result=0.
- Arithmetic uses XLEN+1-bit subtraction for the divider and a 2·XLEN accumulator for the multiplier. No combinational path from in_valid to out_valid.

Decomposition:
- Shared constants (include file next to `RegBus`):
  - MDU op codes.
  - `MDU_IDLE`/`MDU_CALC`/`MDU_FIX`/`MDU_DONE` state encodings.
  - XLEN tied to `RegBus` width.
- Sub-module: `mdu_signfix`, combinational. Handles operand extension, absolute value and final negation/selection. Used at entry and in FIX.
- The FSM, counter and datapath registers stay in mdu_iter.

Test Plan:
1. MUL 7×(-3) (opnum2=0xFFFF_FFFF_FFFF_FFFD) → result 0xFFFF_FFFF_FFFF_FFEB, out_valid at cycle 66; in_ready=0 and busy=1 throughout.
2. MULHU 0xFFFF_FFFF_FFFF_FFFF × 0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE. MULH with the same operands → 0.
3. DIV -7/2 → 0xFFFF_FFFF_FFFF_FFFD. REM -7/2 → 0xFFFF_FFFF_FFFF_FFFF. DIVW 0x0000_0001_8000_0000 / 0xFFFF_FFFF (−1 at 32 bits) → 0xFFFF_FFFF_8000_0000 at cycle 1 (overflow path).
4. DIVU x/0 → all ones at cycle 1. REMU 123/0 → 123. DIV of 0x8000_0000_0000_0000 by -1 → 0x8000_0000_0000_0000. REM of the same → 0.
5. Hold out_ready=0 for 5 cycles in DONE → result stable and out_valid held; in_ready returns 1 cycle after the handshake.
6. Flush at cycle 10 of a DIV → out_valid never asserts, in_ready=1 next cycle, a following MULW 0x7FFF_FFFF×2 → 0xFFFF_FFFF_FFFF_FFFE. Also drop rst_n mid-CALC → all outputs reset immediately without waiting for a clock edge.

Source files
------------

// File: rtl/mdu_iter_pkg.sv
// mdu_iter_pkg: shared widths, op codes, FSM states and op-class helpers for the iterative multiply/divide unit
package mdu_iter_pkg;
  localparam int REG_BUS = 64;
  localparam int MDU_XLEN = REG_BUS;
  localparam int MDU_CNT_W = 7;
  localparam logic [3:0] OP_MUL = 4'd0;
  localparam logic [3:0] OP_MULH = 4'd1;
  localparam logic [3:0] OP_MULHSU = 4'd2;
  localparam logic [3:0] OP_MULHU = 4'd3;
  localparam logic [3:0] OP_DIV = 4'd4;
  localparam logic [3:0] OP_DIVU = 4'd5;
  localparam logic [3:0] OP_REM = 4'd6;
  localparam logic [3:0] OP_REMU = 4'd7;
  localparam logic [3:0] OP_MULW = 4'd8;
  localparam logic [3:0] OP_DIVW = 4'd9;
  localparam logic [3:0] OP_DIVUW = 4'd10;
  localparam logic [3:0] OP_REMW = 4'd11;
  localparam logic [3:0] OP_REMUW = 4'd12;
  typedef enum logic [1:0] {MDU_IDLE, MDU_CALC, MDU_FIX, MDU_DONE} mdu_state_e;
  function automatic logic op_w(input logic [3:0] op);
    return op >= OP_MULW && op <= OP_REMUW;
  endfunction
  function automatic logic op_div(input logic [3:0] op);
    return (op >= OP_DIV && op <= OP_REMU) || (op >= OP_DIVW && op <= OP_REMUW);
  endfunction
  function automatic logic op_rem(input logic [3:0] op);
    return op == OP_REM || op == OP_REMU || op == OP_REMW || op == OP_REMUW;
  endfunction
  function automatic logic op_sgn2(input logic [3:0] op);
    return op == OP_MULH || op == OP_DIV || op == OP_REM || op == OP_DIVW || op == OP_REMW;
  endfunction
  function automatic logic op_sgn1(input logic [3:0] op);
    return op_sgn2(op) || op == OP_MULHSU;
  endfunction
  function automatic logic op_rsvd(input logic [3:0] op);
    return op > OP_REMUW;
  endfunction
endpackage

// File: rtl/mdu_signfix.sv
// mdu_signfix: operand extension/absolute value at entry and final negation/result selection at fix
module mdu_signfix
  import mdu_iter_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic [3:0]        op,
  input  logic [XLEN-1:0]   opnum1,
  input  logic [XLEN-1:0]   opnum2,
  output logic [XLEN-1:0]   ext1,
  output logic [XLEN-1:0]   ext2,
  output logic [XLEN-1:0]   abs1,
  output logic [XLEN-1:0]   abs2,
  output logic              neg1,
  output logic              neg2,
  input  logic [3:0]        fix_op,
  input  logic              fix_neg,
  input  logic [2*XLEN-1:0] acc,
  output logic [XLEN-1:0]   fix_res
);
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] sprod;
  logic [XLEN-1:0] qr;
  logic [XLEN-1:0] sqr;
  logic [XLEN-1:0] raw;
  always_comb begin
    ext1 = op_w(op) ? (op_sgn1(op) ? {{(XLEN-32){opnum1[31]}}, opnum1[31:0]} : {{(XLEN-32){1'b0}}, opnum1[31:0]}) : opnum1;
    ext2 = op_w(op) ? (op_sgn2(op) ? {{(XLEN-32){opnum2[31]}}, opnum2[31:0]} : {{(XLEN-32){1'b0}}, opnum2[31:0]}) : opnum2;
    neg1 = op_sgn1(op) & ext1[XLEN-1];
    neg2 = op_sgn2(op) & ext2[XLEN-1];
    abs1 = neg1 ? -ext1 : ext1;
    abs2 = neg2 ? -ext2 : ext2;
    prod = op_w(fix_op) ? acc >> 32 : acc;
    sprod = fix_neg ? -prod : prod;
    qr = op_rem(fix_op) ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    sqr = fix_neg ? -qr : qr;
    raw = op_div(fix_op) ? sqr : (fix_op == OP_MUL || op_w(fix_op)) ? sprod[XLEN-1:0] : sprod[2*XLEN-1:XLEN];
    fix_res = op_w(fix_op) ? {{(XLEN-32){raw[31]}}, raw[31:0]} : raw;
  end
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV64M multiply/divide unit with valid/ready handshake and flush
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int XLEN  = MDU_XLEN,
  parameter int CNT_W = MDU_CNT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] opnum1,
  input  logic [XLEN-1:0] opnum2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  mdu_state_e state, state_d;
  logic [3:0] op_q;
  logic neg_q;
  logic [XLEN-1:0] opb_q;
  logic [2*XLEN-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] ext1, ext2, abs1, abs2, fix_res;
  logic neg1, neg2;
  logic accept, dz, ovf, special;
  logic [XLEN-1:0] sp_val, sp_res;
  logic [XLEN:0] mul_sum, div_diff;
  logic [2*XLEN-1:0] mul_nxt, div_nxt;
  mdu_signfix #(.XLEN(XLEN)) u_signfix (
    .op      (op),
    .opnum1  (opnum1),
    .opnum2  (opnum2),
    .ext1    (ext1),
    .ext2    (ext2),
    .abs1    (abs1),
    .abs2    (abs2),
    .neg1    (neg1),
    .neg2    (neg2),
    .fix_op  (op_q),
    .fix_neg (neg_q),
    .acc     (acc),
    .fix_res (fix_res)
  );
  assign in_ready = state == MDU_IDLE;
  assign busy = state != MDU_IDLE;
  assign out_valid = state == MDU_DONE;
  assign accept = in_valid && in_ready && !flush;
  always_comb begin
    dz = op_div(op) && ext2 == '0;
    ovf = op_div(op) && op_sgn1(op) && &ext2 &&
          ext1 == (op_w(op) ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}});
    special = dz || ovf || op_rsvd(op);
    sp_val = op_rsvd(op) ? '0 : dz ? (op_rem(op) ? ext1 : {XLEN{1'b1}}) : (op_rem(op) ? '0 : ext1);
    sp_res = op_w(op) ? {{(XLEN-32){sp_val[31]}}, sp_val[31:0]} : sp_val;
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    mul_nxt = {mul_sum, acc[XLEN-1:1]};
    div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
    div_nxt = {div_diff[XLEN] ? acc[2*XLEN-2:XLEN-1] : div_diff[XLEN-1:0], acc[XLEN-2:0], ~div_diff[XLEN]};
  end
  always_comb begin
    state_d = state;
    if (flush) state_d = MDU_IDLE;
    else if (state == MDU_IDLE) state_d = in_valid ? (special ? MDU_DONE : MDU_CALC) : MDU_IDLE;
    else if (state == MDU_CALC) state_d = cnt == CNT_W'(1) ? MDU_FIX : MDU_CALC;
    else if (state == MDU_FIX) state_d = MDU_DONE;
    else state_d = out_ready ? MDU_IDLE : MDU_DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= MDU_IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_q <= '0;
      neg_q <= 1'b0;
      opb_q <= '0;
      acc <= '0;
      cnt <= '0;
      result <= '0;
    end else if (accept) begin
      op_q <= op;
      neg_q <= op_rem(op) ? neg1 : neg1 ^ neg2;
      cnt <= op_w(op) ? CNT_W'(32) : CNT_W'(XLEN);
      opb_q <= op_div(op) ? abs2 : abs1;
      acc <= {{XLEN{1'b0}}, op_div(op) ? (op_w(op) ? {abs1[31:0], {(XLEN-32){1'b0}}} : abs1) : abs2};
      result <= special ? sp_res : result;
    end else if (state == MDU_CALC) begin
      cnt <= cnt - CNT_W'(1);
      acc <= op_div(op_q) ? div_nxt : mul_nxt;
    end else if (state == MDU_FIX && !flush) begin
      result <= fix_res;
    end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed self-checking bench for mdu_iter
module tb_mdu_iter;
  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic in_ready;
  logic [3:0] op;
  logic [63:0] opnum1;
  logic [63:0] opnum2;
  logic flush;
  logic out_valid;
  logic out_ready;
  logic [63:0] result;
  logic busy;
  int checks = 0;
  int errors = 0;
  logic [63:0] r;
  int c;
  logic s;
  logic seen;
  mdu_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .opnum1    (opnum1),
    .opnum2    (opnum2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                     output logic [63:0] res, output int cyc, output logic stall);
    stall = 1'b1;
    op = o;
    opnum1 = a;
    opnum2 = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      stall &= !in_ready && busy;
      @(posedge clk); #1;
      cyc++;
    end
    res = result;
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask
  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    op = '0;
    opnum1 = '0;
    opnum2 = '0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    run(4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, r, c, s);
    check("mul_res", r, 64'hFFFF_FFFF_FFFF_FFEB);
    check("mul_cyc", c, 66);
    check("mul_stall", s, 1);
    run(4'd3, '1, '1, r, c, s);
    check("mulhu_res", r, 64'hFFFF_FFFF_FFFF_FFFE);
    run(4'd1, '1, '1, r, c, s);
    check("mulh_res", r, 64'h0);
    check("mulh_cyc", c, 66);
    run(4'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, r, c, s);
    check("mulhsu_res", r, 64'hFFFF_FFFF_FFFF_FFFF);
    run(4'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, r, c, s);
    check("div_res", r, 64'hFFFF_FFFF_FFFF_FFFD);
    check("div_cyc", c, 66);
    run(4'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, r, c, s);
    check("rem_res", r, 64'hFFFF_FFFF_FFFF_FFFF);
    run(4'd9, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, r, c, s);
    check("divw_ovf_res", r, 64'hFFFF_FFFF_8000_0000);
    check("divw_ovf_cyc", c, 1);
    run(4'd9, 64'h0000_0000_FFFF_FF9C, 64'd7, r, c, s);
    check("divw_res", r, 64'hFFFF_FFFF_FFFF_FFF2);
    check("divw_cyc", c, 34);
    run(4'd11, 64'h0000_0000_FFFF_FF9C, 64'd7, r, c, s);
    check("remw_res", r, 64'hFFFF_FFFF_FFFF_FFFE);
    run(4'd5, 64'd12345, 64'd0, r, c, s);
    check("divu_z_res", r, '1);
    check("divu_z_cyc", c, 1);
    run(4'd7, 64'd123, 64'd0, r, c, s);
    check("remu_z_res", r, 64'd123);
    run(4'd4, 64'h8000_0000_0000_0000, '1, r, c, s);
    check("div_ovf_res", r, 64'h8000_0000_0000_0000);
    check("div_ovf_cyc", c, 1);
    run(4'd6, 64'h8000_0000_0000_0000, '1, r, c, s);
    check("rem_ovf_res", r, 64'h0);
    run(4'd12, 64'h0000_0000_8000_0005, 64'd0, r, c, s);
    check("remuw_z_res", r, 64'hFFFF_FFFF_8000_0005);
    run(4'd14, 64'd5, 64'd6, r, c, s);
    check("rsvd_res", r, 64'h0);
    check("rsvd_cyc", c, 1);
    out_ready = 1'b0;
    run(4'd5, 64'd100, 64'd7, r, c, s);
    check("hold_first", r, 64'd14);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_res", result, 64'd14);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_hs_in_ready", in_ready, 1);
    check("post_hs_valid", out_valid, 0);
    op = 4'd4;
    opnum1 = 64'd1000;
    opnum2 = 64'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    in_valid = 1'b1;
    op = 4'd0;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_in_ready", in_ready, 1);
    check("flush_busy", busy, 0);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_valid", seen, 0);
    run(4'd8, 64'h0000_0000_7FFF_FFFF, 64'd2, r, c, s);
    check("mulw_res", r, 64'hFFFF_FFFF_FFFF_FFFE);
    check("mulw_cyc", c, 34);
    op = 4'd0;
    opnum1 = 64'd6;
    opnum2 = 64'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_in_ready", in_ready, 1);
    check("arst_busy", busy, 0);
    check("arst_valid", out_valid, 0);
    check("arst_result", result, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(4'd0, 64'd6, 64'd7, r, c, s);
    check("post_rst_mul", r, 64'd42);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
